bcd_converter: RTL
==================

# bcd_converter

Parametrised, handshaked binary-to-BCD converter. Successor to the free-running `bcd_encoder`; adds:
- a start/busy/valid handshake
- an optional two's-complement input mode
- overflow detection with saturation
- a leading-zero blanking mask

It sits between arithmetic/measurement logic and the seven-segment/display drivers. It converts one value per request using a shift-and-add-3 (double-dabble) sequence, one bit per clock.

## Interface
Parameters:
- `BINARY_LENGTH`, 7: width N of `binary_data`, N ≥ 2.
- `DECIMAL_LENGTH`, 4: number of output BCD digits D, D ≥ 1.
- `SIGNED`, 0: 1 means `binary_data` is two's complement; 0 means unsigned.

Ports:
- `CLK` in 1: single clock, all logic on the rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `start` in 1: conversion request, sampled only in IDLE.
- `binary_data` in N: value to convert, captured on the accepting edge.
- `BCD_data` out 4·D: result; digit i is `[4i+3:4i]`, digit 0 is least significant.
- `BCD_ready` out 1: one-cycle pulse marking a new result.
- `busy` out 1: high while a conversion is in flight.
- `negative` out 1: sign of the last result (SIGNED=1 only; otherwise 0).
- `overflow` out 1: last magnitude exceeded 10^D − 1.
- `digit_enable` out D: blanking mask; bit i = 1 if digit i or any more-significant digit is non-zero; bit 0 is always 1.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - When `start`=1, capture the magnitude into the shift register, clear the BCD scratch and the sticky overflow, set count=0, go to SHIFT.
  - Magnitude: `binary_data` as-is if SIGNED=0 or the MSB is 0; otherwise its two's-complement negation (N bits unsigned). −2^(N−1) yields 2^(N−1) and is valid.
- SHIFT, one step per cycle:
  - Add 3 to every scratch digit that is ≥ 5.
  - Shift scratch and binary left as one register.
  - If the bit leaving the top of the scratch is 1, set sticky overflow.
  - After N steps go to DONE.
- DONE, one cycle:
  - Register the outputs and pulse `BCD_ready`, then go to IDLE.
  - If overflow: `BCD_data` = all digits 9, `digit_enable` = all ones.
  - Otherwise `BCD_data` = scratch and `digit_enable` is computed from the scratch.
  - `negative` is set only when the input was negative and the magnitude is non-zero, so −0 cannot occur.
- Outputs hold their last result until the next DONE.
- `start` while busy is ignored: no queueing, and the captured `binary_data` is unaffected.

## Timing
- Edge k: `start` is sampled high in IDLE. From k on, `busy`=1.
- Edges k+1 … k+N: the N shift steps.
- Edge k+N+1: `BCD_data`, `negative`, `overflow` and `digit_enable` update. From that edge `BCD_ready`=1 for exactly one cycle and `busy`=0.
  - Latency is N+1 edges; the default is 8.
- A `start` sampled at edge k+N+2 (while `BCD_ready` is high) is accepted. Back-to-back throughput is one result per N+2 cycles.
- Reset values:
  - `BCD_data`=0, `BCD_ready`=0, `busy`=0, `negative`=0, `overflow`=0.
  - `digit_enable`=1 (only bit 0 set).
  - State=IDLE.
- `RST` during SHIFT or DONE: abort, no `BCD_ready` pulse, and all outputs go to their reset values at that edge.
- `RST` and `start` high on the same edge: reset wins and the request is dropped.

## Test plan
- Defaults, 54 then 122, each with a one-cycle `start`:
  - 54 → `BCD_data`=0x0054, `digit_enable`=0011, `BCD_ready` 8 edges after accept.
  - 122 → 0x0122, `digit_enable`=0111, `overflow`=0.
- Defaults, 0 → `BCD_data`=0x0000, `digit_enable`=0001.
- D=2, N=7, input 122 → `overflow`=1, `BCD_data`=0x99, `digit_enable`=11.
- SIGNED=1, N=8:
  - 0x80 → `BCD_data`=0x0128, `negative`=1.
  - 0xE9 → 0x0023, `negative`=1.
  - 0x17 → 0x0023, `negative`=0.
- Defaults, start 54:
  - Pulse `start` with 23 on edges k+3 and k+N+1 → both ignored; the result is 0x0054.
  - `start` with 23 held on edge k+N+2 → accepted; 0x0023 appears N+1 edges later.
- Defaults, start 122, assert `RST` at edge k+4:
  - No `BCD_ready` pulse; outputs at reset values; `busy`=0.
  - A fresh `start` with 54 then completes normally.

Source files
------------

// File: rtl/bcd_converter.sv
// Handshaked binary-to-BCD converter using double-dabble, one bit per clock.
// Supports a two's-complement input mode, overflow saturation to all nines, and a leading-zero blanking mask.

module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module bcd_converter #(
  parameter int BINARY_LENGTH  = 7,
  parameter int DECIMAL_LENGTH = 4,
  parameter bit SIGNED         = 1'b0
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        start,
  input  logic [BINARY_LENGTH-1:0]    binary_data,
  output logic [4*DECIMAL_LENGTH-1:0] BCD_data,
  output logic                        BCD_ready,
  output logic                        busy,
  output logic                        negative,
  output logic                        overflow,
  output logic [DECIMAL_LENGTH-1:0]   digit_enable
);
  localparam int N  = BINARY_LENGTH;
  localparam int D  = DECIMAL_LENGTH;
  localparam int SW = 4 * D;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   bin_q, bin_d;
  logic [SW-1:0]  scr_q, scr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sovf_q, sovf_d;
  logic           nin_q, nin_d;
  logic [SW-1:0]  bcd_q, bcd_d;
  logic           rdy_q, rdy_d;
  logic           neg_q, neg_d;
  logic           ovf_q, ovf_d;
  logic [D-1:0]   den_q, den_d;

  logic [SW-1:0]  scr_adj;
  logic [D-1:0]   den_calc;
  logic           nz;
  logic           is_neg;
  logic [N-1:0]   mag;

  for (genvar i = 0; i < D; i++) begin : g_dig
    bcd_add3 u_add3 (.din(scr_q[4*i +: 4]), .dout(scr_adj[4*i +: 4]));
  end

  // The most negative input negates to itself, which read unsigned is the correct magnitude.
  assign is_neg = SIGNED && binary_data[N-1];
  assign mag    = is_neg ? (~binary_data + 1'b1) : binary_data;

  always_comb begin
    nz       = 1'b0;
    den_calc = '0;
    for (int i = D - 1; i >= 0; i--) begin
      nz          = nz | (scr_q[4*i +: 4] != 4'd0);
      den_calc[i] = nz;
    end
    den_calc[0] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      sovf_q  <= 1'b0;
      nin_q   <= 1'b0;
      bcd_q   <= '0;
      rdy_q   <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      den_q   <= D'(1);
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      sovf_q  <= sovf_d;
      nin_q   <= nin_d;
      bcd_q   <= bcd_d;
      rdy_q   <= rdy_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      den_q   <= den_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CW'(N - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bin_d  = bin_q;
    scr_d  = scr_q;
    cnt_d  = cnt_q;
    sovf_d = sovf_q;
    nin_d  = nin_q;
    bcd_d  = bcd_q;
    rdy_d  = 1'b0;
    neg_d  = neg_q;
    ovf_d  = ovf_q;
    den_d  = den_q;
    case (state_q)
      IDLE: if (start) begin
        bin_d  = mag;
        scr_d  = '0;
        cnt_d  = '0;
        sovf_d = 1'b0;
        nin_d  = is_neg && (mag != '0);
      end
      SHIFT: begin
        // A one falling off the top digit means the value no longer fits in D digits.
        {scr_d, bin_d} = {scr_adj[SW-2:0], bin_q, 1'b0};
        sovf_d         = sovf_q | scr_adj[SW-1];
        cnt_d          = cnt_q + 1'b1;
      end
      DONE: begin
        rdy_d = 1'b1;
        neg_d = nin_q;
        ovf_d = sovf_q;
        if (sovf_q) begin
          bcd_d = {D{4'h9}};
          den_d = '1;
        end else begin
          bcd_d = scr_q;
          den_d = den_calc;
        end
      end
      default: ;
    endcase
  end

  assign busy         = (state_q != IDLE);
  assign BCD_data     = bcd_q;
  assign BCD_ready    = rdy_q;
  assign negative     = neg_q;
  assign overflow     = ovf_q;
  assign digit_enable = den_q;
endmodule
